// File: rtl/count_sequencer_if.sv
// Control, status and counter-feedback signals between the count sequencer and its host/counter.
interface count_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
);
  logic             START;
  logic             STOP;
  logic             PAUSE;
  logic             MODE;
  logic [PRE_W-1:0] DIV;
  logic [CNT_W-1:0] LIMIT;
  logic [CNT_W-1:0] Q;
  logic             CNT_CLR;
  logic             CNT_EN;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  modport master (
    output START, STOP, PAUSE, MODE, DIV, LIMIT, Q,
    input  CNT_CLR, CNT_EN, BUSY, DONE, ERR
  );

  modport slave (
    input  START, STOP, PAUSE, MODE, DIV, LIMIT, Q,
    output CNT_CLR, CNT_EN, BUSY, DONE, ERR
  );
endinterface

// File: rtl/count_sequencer.sv
// Sequences an external synchronous counter: clear, prescaled enable strobes,
// and one-shot or periodic termination at a latched limit.
module count_sequencer #(
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  count_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [PRE_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic             tick_s;
  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic             done_s;

  // State and latched configuration registers.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      presc_q <= {PRE_W{1'b0}};
      div_q   <= {PRE_W{1'b0}};
      limit_q <= {CNT_W{1'b0}};
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // Next-state and strobe decode; PAUSE/STOP gate the RUN strobes directly.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    div_d     = div_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    err_d     = err_q;
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;
    done_s    = 1'b0;
    tick_s    = (presc_q == div_q) && !bus.PAUSE;

    case (state_q)
      IDLE: begin
        if (bus.START && !bus.STOP) begin
          state_d = CLEAR;
          mode_d  = bus.MODE;
          div_d   = bus.DIV;
          limit_d = bus.LIMIT;
          err_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        cnt_clr_s = 1'b1;
        presc_d   = {PRE_W{1'b0}};
        state_d   = RUN;
        if (bus.START) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      RUN: begin
        if (bus.START) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (bus.STOP) begin
          state_d = IDLE;
          presc_d = {PRE_W{1'b0}};
        end else if (bus.PAUSE) begin
          presc_d = presc_q;
        end else if (!tick_s) begin
          presc_d = presc_q + PRE_W'(1);
        end else if (bus.Q != limit_q) begin
          // Q above limit also lands here, so a corrupted counter wraps back around.
          cnt_en_s = 1'b1;
          presc_d  = {PRE_W{1'b0}};
        end else begin
          done_s  = 1'b1;
          presc_d = {PRE_W{1'b0}};
          if (mode_q) begin
            cnt_clr_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.CNT_CLR = cnt_clr_s;
  assign bus.CNT_EN  = cnt_en_s;
  assign bus.DONE    = done_s;
  assign bus.BUSY    = (state_q != IDLE);
  assign bus.ERR     = err_q;

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Synchronous controller that sequences the 16-bit counter datapath: it drives the counter's clear and count-enable strobes from a programmable prescaler.
- Watches the counter value fed back on Q and stops (one-shot) or restarts (periodic) at a programmable limit.
- Replaces ripple/skewed clocking of the low bits: all counter flops run on CLK and are qualified by CNT_EN.

Parameters:
CNT_W, 16, width of counter value and LIMIT
PRE_W, 8, width of prescaler and DIV

Ports:
CLK  in  1  system clock; all state on rising edge
CLR  in  1  asynchronous active-high reset
START  in  1  request to begin a count run; sampled each cycle
STOP  in  1  abort run, return to IDLE
PAUSE  in  1  freeze prescaler and suppress CNT_EN while high in RUN
MODE  in  1  0 = one-shot, 1 = periodic
DIV  in  PRE_W  prescale: counter advances once per DIV+1 cycles
LIMIT  in  CNT_W  terminal counter value
Q  in  CNT_W  current counter value (registered counter output)
CNT_CLR  out  1  synchronous clear strobe to counter (clear has priority over enable in counter)
CNT_EN  out  1  one-cycle increment strobe to counter
BUSY  out  1  high in CLEAR and RUN
DONE  out  1  one-cycle pulse at terminal count
ERR  out  1  sticky: START received while BUSY

Behaviour:
- Reset (CLR=1, async): state=IDLE; presc=0; mode_l, div_l, limit_l=0; CNT_CLR, CNT_EN, DONE, ERR, BUSY=0. After CLR falls, nothing happens until START.
- States: IDLE, CLEAR, RUN. Outputs are decoded from registered state, registered presc and Q. No combinational path from START/STOP to outputs, except PAUSE/STOP gating CNT_EN and DONE in RUN.
- IDLE:
  - START=1 and STOP=0 -> CLEAR.
  - Latch MODE, DIV, LIMIT into mode_l, div_l, limit_l; clear ERR.
  - START with STOP=1 is ignored (STOP wins).
- CLEAR (one cycle): CNT_CLR=1, presc<=0 -> RUN.
- RUN:
  - tick = (presc==div_l) && !PAUSE.
  - PAUSE=1: presc holds; CNT_EN=0; DONE=0.
  - STOP=1 has top priority: next state IDLE; CNT_EN=0, DONE=0, CNT_CLR=0. The counter keeps its value.
  - !tick && !PAUSE: presc<=presc+1.
  - tick && Q!=limit_l: CNT_EN=1, presc<=0.
  - tick && Q==limit_l (terminal):
    - DONE=1, CNT_EN=0, presc<=0.
    - mode_l=0: next state IDLE; counter holds LIMIT.
    - mode_l=1: CNT_CLR=1 same cycle, stay RUN.
- Timing:
  - START accepted in cycle n -> CNT_CLR in n+1 -> first CNT_EN in n+2+div_l.
  - Each counter value is held DIV+1 cycles.
  - One-shot: DONE asserts (LIMIT+1)*(DIV+1) cycles after the CLEAR cycle.
  - Periodic: DONE period is exactly (LIMIT+1)*(DIV+1) cycles, with no gap cycle.
- START while BUSY: ignored, ERR<=1 (sticky until the next accepted START or CLR). DIV/LIMIT/MODE changes while BUSY have no effect.
- Boundaries:
  - DIV=0: tick every non-paused cycle.
  - LIMIT=0: DONE on first tick, no CNT_EN ever issued.
  - LIMIT=2^CNT_W-1: full range, counter never wraps under controller.
  - presc is compared for equality only, so no wrap is reachable.
- If Q exceeds limit_l (external corruption), the controller keeps enabling. The counter wraps through 0 and terminates on reaching limit_l. No lockup.
- CLR mid-run: immediate IDLE; outputs 0 asynchronously; counter state is not touched by the controller.

Test Plan:
- Reset: CLR=1 for 3 cycles with START=1 -> all outputs 0, state IDLE. After release with START=0 -> outputs stay 0 for 10 cycles.
- One-shot, DIV=2, LIMIT=3, MODE=0, counter model attached:
  - START pulse -> CNT_CLR 1 cycle later.
  - CNT_EN every 3rd cycle, 3 strobes total; Q steps 0,1,2,3.
  - DONE single pulse 12 cycles after the CLEAR cycle; BUSY falls same edge; Q holds 3.
- Periodic, DIV=0, LIMIT=4, MODE=1 -> DONE every 5 cycles, with CNT_CLR coincident with DONE. Q sequence 0..4 repeating for 4 periods.
- PAUSE and STOP:
  - DIV=1, LIMIT=10: PAUSE high for 7 cycles at Q=5 -> no CNT_EN; presc frozen; DONE delayed by exactly 7 cycles.
  - Separate run: STOP on a terminal-tick cycle -> no DONE; IDLE next cycle.
- ERR: START during RUN -> ERR=1, run unaffected and DONE still on time. Next START in IDLE -> ERR=0 and new run begins.
- Limits: LIMIT=0, DIV=0 -> DONE one cycle after CLEAR, zero CNT_EN. LIMIT=16'hFFFF, DIV=0, one-shot -> 65535 CNT_EN strobes, DONE at Q=16'hFFFF.
